// File: rtl/fifo_to_axi_wr.sv
// Pops one word from a sync FIFO and writes it to DDR as a single-beat AXI burst.
// Optional WR_ERR_CNT_EN adds err_cnt, a saturating count of SLVERR/DECERR responses.
module fifo_to_axi_wr #(
   parameter int                    DATA_WIDTH   = 128,
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int                    REGION_WORDS = 1024
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    fifo_empty,
   output logic                    fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]   fifo_dout,
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [7:0]              awlen,
   output logic [2:0]              awsize,
   output logic [1:0]              awburst,
   output logic                    awvalid,
   input  logic                    awready,
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wlast,
   output logic                    wvalid,
   input  logic                    wready,
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
`ifdef WR_ERR_CNT_EN
   output logic [7:0]              err_cnt,
`endif
   output logic                    busy,
   output logic [15:0]             wr_count
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam logic [2:0] SIZE = 3'($clog2(BYTES));
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BYTES);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
      BASE_ADDR + ADDR_WIDTH'((REGION_WORDS - 1) * BYTES);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] POP       = 3'd1;
   localparam logic [2:0] LATCH     = 3'd2;
   localparam logic [2:0] ADDR_DATA = 3'd3;
   localparam logic [2:0] RESP      = 3'd4;

   logic [2:0] state;

   assign awlen   = 8'd0;
   assign awsize  = SIZE;
   assign awburst = 2'b01;
   assign wstrb   = '1;
   assign wlast   = wvalid;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         fifo_rd_en <= 1'b0;
         awvalid    <= 1'b0;
         wvalid     <= 1'b0;
         bready     <= 1'b0;
         awaddr     <= BASE_ADDR;
         wdata      <= '0;
         wr_count   <= 16'd0;
      end else begin
         fifo_rd_en <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  fifo_rd_en <= 1'b1;
                  state      <= POP;
               end
            end
            POP: state <= LATCH;
            LATCH: begin
               wdata   <= fifo_dout;
               awvalid <= 1'b1;
               wvalid  <= 1'b1;
               state   <= ADDR_DATA;
            end
            ADDR_DATA: begin
               if (awready) awvalid <= 1'b0;
               if (wready) wvalid <= 1'b0;
               // both channels may finish in either order or together
               if ((!awvalid || awready) && (!wvalid || wready)) begin
                  bready <= 1'b1;
                  state  <= RESP;
               end
            end
            RESP: begin
               if (bvalid) begin
                  bready   <= 1'b0;
                  wr_count <= wr_count + 16'd1;
                  awaddr   <= (awaddr == LAST_ADDR) ? BASE_ADDR : awaddr + STEP;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef WR_ERR_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_cnt <= 8'd0;
      else if (bvalid && bready && bresp[1] && err_cnt != 8'hFF)
         err_cnt <= err_cnt + 8'd1;
   end
`else
   logic unused_bresp;
   assign unused_bresp = ^bresp;
`endif

endmodule

// File: tb/tb_fifo_to_axi_wr.sv
// Self-checking bench for fifo_to_axi_wr: FIFO and AXI slave models plus
// a transaction-level reference model; define WR_ERR_CNT_EN to cover err_cnt.
module tb_fifo_to_axi_wr;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam int RW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fifo_empty = 1'b1;
   logic fifo_rd_en;
   logic [127:0] fifo_dout = '0;
   logic [31:0] awaddr;
   logic [7:0] awlen;
   logic [2:0] awsize;
   logic [1:0] awburst;
   logic awvalid;
   logic awready = 1'b0;
   logic [127:0] wdata;
   logic [15:0] wstrb;
   logic wlast;
   logic wvalid;
   logic wready = 1'b0;
   logic [1:0] bresp = 2'b00;
   logic bvalid = 1'b0;
   logic bready;
   logic busy;
   logic [15:0] wr_count;
`ifdef WR_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   fifo_to_axi_wr #(
      .DATA_WIDTH(128),
      .ADDR_WIDTH(32),
      .BASE_ADDR(BASE),
      .REGION_WORDS(RW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fifo_empty(fifo_empty),
      .fifo_rd_en(fifo_rd_en),
      .fifo_dout(fifo_dout),
      .awaddr(awaddr),
      .awlen(awlen),
      .awsize(awsize),
      .awburst(awburst),
      .awvalid(awvalid),
      .awready(awready),
      .wdata(wdata),
      .wstrb(wstrb),
      .wlast(wlast),
      .wvalid(wvalid),
      .wready(wready),
      .bresp(bresp),
      .bvalid(bvalid),
      .bready(bready),
`ifdef WR_ERR_CNT_EN
      .err_cnt(err_cnt),
`endif
      .busy(busy),
      .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // slave configuration, written by the main sequence
   bit rnd = 0;
   bit force_err = 0;
   int aw_wait = 0;
   int w_wait = 0;

   logic [127:0] fq[$];
   logic [127:0] exp_q[$];
   logic [31:0] aw_log[$];
   logic [127:0] w_log[$];

   // FIFO model: data appears one cycle after the pop
   always @(posedge clk) begin
      if (!rst && fifo_rd_en) begin
         chk("fifo_underflow", fq.size() != 0, 1'b1);
         if (fq.size() != 0) begin
            logic [127:0] w;
            w = fq.pop_front();
            fifo_dout <= w;
            exp_q.push_back(w);
         end
      end
   end

   always @(negedge clk) fifo_empty = (fq.size() == 0);

   // AXI slave model
   bit s_aw, s_w, s_b;
   int aw_cnt, w_cnt;
   always @(posedge clk) begin
      if (rst) begin
         s_aw = 0; s_w = 0; s_b = 0; aw_cnt = 0; w_cnt = 0;
      end else begin
         if (bvalid && bready) begin
            s_b = 0; s_aw = 0; s_w = 0;
         end
         if (awvalid && awready) s_aw = 1;
         if (wvalid && wready) s_w = 1;
         if (s_aw && s_w) s_b = 1;
         aw_cnt = (awvalid && !awready) ? aw_cnt + 1 : 0;
         w_cnt = (wvalid && !wready) ? w_cnt + 1 : 0;
      end
      #1;
      awready = rnd ? ($urandom % 3 != 0) : (aw_cnt >= aw_wait);
      wready = rnd ? ($urandom % 3 != 0) : (w_cnt >= w_wait);
      if (!s_b) begin
         bvalid = 1'b0;
      end else if (!bvalid) begin
         bvalid = rnd ? 1'($urandom % 2) : 1'b1;
         bresp = force_err ? 2'b10 : (rnd ? 2'($urandom % 4) : 2'b00);
      end
   end

   // reference model and per-cycle compare
   bit in_flight, aw_done, w_done, prev_aw, prev_w;
   int done = 0;
   int err_m = 0;
   int rd_pulses = 0, busy_cycles = 0, aw_hi = 0, w_hi = 0;

   always @(negedge clk) begin
      if (rst) begin
         in_flight = 0; aw_done = 0; w_done = 0;
         prev_aw = 0; prev_w = 0; done = 0; err_m = 0;
         exp_q.delete();
      end else begin
         logic [31:0] exp_addr;
         exp_addr = BASE + 32'((done % RW) * 16);
         chk("wr_count", wr_count, 16'(done));
         chk("busy", busy, fifo_rd_en | in_flight);
         chk("wlast", wlast, wvalid);
         chk("bready", bready, in_flight && aw_done && w_done);
`ifdef WR_ERR_CNT_EN
         chk("err_cnt", err_cnt, 8'(err_m));
`endif
         if (prev_aw) chk("aw_hold", awvalid, 1'b1);
         if (prev_w) chk("w_hold", wvalid, 1'b1);
         if (fifo_rd_en) begin
            chk("one_outstanding", in_flight, 1'b0);
            in_flight = 1;
            rd_pulses++;
         end
         if (awvalid) begin
            chk("aw_repeat", aw_done, 1'b0);
            chk("awaddr", awaddr, exp_addr);
            chk("aw_attr", {awlen, awsize, awburst}, {8'd0, 3'd4, 2'b01});
            aw_hi++;
         end
         if (wvalid) begin
            chk("wdata", wdata, exp_q.size() > 0 ? exp_q[0] : 'x);
            chk("wstrb", wstrb, 16'hFFFF);
            w_hi++;
         end
         if (busy) busy_cycles++;
         prev_aw = awvalid && !awready;
         prev_w = wvalid && !wready;
         if (awvalid && awready) begin
            aw_done = 1;
            aw_log.push_back(awaddr);
         end
         if (wvalid && wready) begin
            w_done = 1;
            w_log.push_back(wdata);
         end
         if (bvalid && bready) begin
            done++;
            if (bresp[1] && err_m < 255) err_m++;
            aw_done = 0; w_done = 0; in_flight = 0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
      end
   end

   function automatic logic [31:0] aw_at(int i);
      if (i < aw_log.size()) return aw_log[i];
      return 'x;
   endfunction

   function automatic logic [127:0] w_at(int i);
      if (i < w_log.size()) return w_log[i];
      return 'x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_wr(input int n, input int budget, input string name);
      int k = 0;
      while (wr_count != 16'(n) && k < budget) begin
         tick();
         k++;
      end
      chk(name, wr_count, 16'(n));
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 50) begin
         tick();
         k++;
      end
      chk("idle_timeout", busy, 1'b0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int b, bb, br, ba, bw;
      logic [127:0] w0, wa, wc, wf;
      w0 = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;
      wa = {32{4'hA}};
      wc = {32{4'hC}};
      wf = {32{4'hF}};

      repeat (2) tick();
      chk("rst_awvalid", awvalid, 1'b0);
      chk("rst_wvalid", wvalid, 1'b0);
      chk("rst_bready", bready, 1'b0);
      chk("rst_wlast", wlast, 1'b0);
      chk("rst_rd_en", fifo_rd_en, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wr_count", wr_count, 16'd0);
      chk("rst_awaddr", awaddr, BASE);
      chk("rst_wdata", wdata, 128'd0);
      rst = 1'b0;
      tick();

      // single word, zero-wait slave
      b = aw_log.size();
      bb = busy_cycles;
      fq.push_back(w0);
      wait_wr(1, 50, "t1_wr_count");
      wait_idle();
      chk("t1_busy_cycles", busy_cycles - bb, 4);
      chk("t1_awaddr", aw_at(b), 32'h0000_1000);
      chk("t1_wdata", w_at(b), w0);

      // three words in order
      do_reset();
      b = aw_log.size();
      br = rd_pulses;
      fq.push_back(wa);
      fq.push_back(wc);
      fq.push_back(wf);
      wait_wr(3, 100, "t2_wr_count");
      wait_idle();
      chk("t2_addr0", aw_at(b), 32'h0000_1000);
      chk("t2_addr1", aw_at(b + 1), 32'h0000_1010);
      chk("t2_addr2", aw_at(b + 2), 32'h0000_1020);
      chk("t2_data2", w_at(b + 2), wf);
      chk("t2_pops", rd_pulses - br, 3);

      // AW accepted four cycles late, W immediately
      do_reset();
      aw_wait = 4;
      ba = aw_hi;
      bw = w_hi;
      fq.push_back(wc);
      wait_wr(1, 50, "t3_wr_count");
      chk("t3_aw_cycles", aw_hi - ba, 5);
      chk("t3_w_cycles", w_hi - bw, 1);
      aw_wait = 0;
      wait_idle();

      // region wrap after four words
      do_reset();
      b = aw_log.size();
      repeat (5) fq.push_back({4{$urandom}});
      wait_wr(5, 150, "t4_wr_count");
      wait_idle();
      chk("t4_addr3", aw_at(b + 3), 32'h0000_1030);
      chk("t4_addr4", aw_at(b + 4), BASE);

      // reset while stalled in the address/data phase
      do_reset();
      fq.push_back(wa);
      wait_wr(1, 50, "t5_first");
      aw_wait = 1000;
      w_wait = 1000;
      fq.push_back(wc);
      begin
         int k = 0;
         while (!awvalid && k < 50) begin
            tick();
            k++;
         end
      end
      chk("t5_stalled", awvalid, 1'b1);
      rst = 1'b1;
      #1;
      chk("t5_rst_awvalid", awvalid, 1'b0);
      chk("t5_rst_wvalid", wvalid, 1'b0);
      chk("t5_rst_wr_count", wr_count, 16'd0);
      chk("t5_rst_awaddr", awaddr, BASE);
      repeat (2) tick();
      aw_wait = 0;
      w_wait = 0;
      rst = 1'b0;
      tick();
      b = aw_log.size();
      fq.push_back(wf);
      wait_wr(1, 50, "t5_after");
      chk("t5_addr", aw_at(b), BASE);
      chk("t5_data", w_at(b), wf);
      wait_idle();

`ifdef WR_ERR_CNT_EN
      do_reset();
      force_err = 1;
      b = aw_log.size();
      fq.push_back(wa);
      fq.push_back(wc);
      wait_wr(2, 80, "t6_wr_count");
      chk("t6_err_cnt", err_cnt, 8'd2);
      chk("t6_addr1", aw_at(b + 1), 32'h0000_1010);
      force_err = 0;
      wait_idle();
`endif

      // randomized traffic with a random-ready slave
      do_reset();
      rnd = 1;
      for (int i = 0; i < 300; i++) begin
         fq.push_back({$urandom, $urandom, $urandom, $urandom});
         repeat ($urandom % 8) tick();
      end
      wait_wr(300, 20000, "rand_wr_count");
      rnd = 0;
      wait_idle();
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_to_axi_wr.md
FIFO_TO_AXI_WR -- requirements
Module: fifo_to_axi_wr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, meaning width of packed FIFO word and AXI write data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning AXI address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, meaning DDR byte address of first word.
REQ-004 SHALL have parameter REGION_WORDS, default 1024, meaning number of words written before address wraps to BASE_ADDR.
REQ-005 SHALL have ports: clk  in  1  system clock, single clock domain.
REQ-006 rst  in  1  reset. Reset is asynchronous and active-high.
REQ-007 fifo_empty  in  1  sync FIFO empty flag.
REQ-008 fifo_rd_en  out  1  FIFO pop, one-cycle pulse.
REQ-009 fifo_dout  in  DATA_WIDTH  FIFO read data, valid one cycle after fifo_rd_en.
REQ-010 awaddr  out  ADDR_WIDTH; awlen  out  8; awsize  out  3; awburst  out  2; awvalid  out  1; awready  in  1.
REQ-011 wdata  out  DATA_WIDTH; wstrb  out  DATA_WIDTH/8; wlast  out  1; wvalid  out  1; wready  in  1.
REQ-012 bresp  in  2; bvalid  in  1; bready  out  1.
REQ-013 busy  out  1  high in any state other than IDLE; wr_count  out  16  completed writes, wraps at 16'hFFFF.

Function
REQ-014 SHALL implement FSM states IDLE, POP, LATCH, ADDR_DATA, RESP.
REQ-015 IDLE: when fifo_empty=0, assert fifo_rd_en for exactly one cycle and go to POP; no pop while fifo_empty=1.
REQ-016 POP -> LATCH unconditionally; LATCH captures fifo_dout into wdata register, drives awvalid=1 and wvalid=1 simultaneously, goes to ADDR_DATA.
REQ-017 Every transaction SHALL be a single beat: awlen=0, awsize=log2(DATA_WIDTH/8) (4 for 128), awburst=2'b01, wstrb all ones, wlast=1 whenever wvalid=1.
REQ-018 ADDR_DATA: awvalid drops the cycle after awready&awvalid; wvalid drops the cycle after wready&wvalid; handshakes may complete in either order or same cycle; go to RESP only once both complete.
REQ-019 awaddr, awvalid, wdata, wvalid SHALL remain stable while valid and not yet accepted.
REQ-020 RESP: bready=1; on bvalid, increment wr_count, advance address, return to IDLE; bready=0 in all other states.
REQ-021 Address advances by DATA_WIDTH/8 per completed write; after REGION_WORDS writes it returns to BASE_ADDR.
REQ-022 Address advances and wr_count increments regardless of bresp value (no retry).
REQ-023 Minimum cycles per word with zero-wait slave: IDLE->POP->LATCH->ADDR_DATA->RESP->IDLE = 5 cycles.
REQ-024 At most one outstanding transaction at any time.

Reset
REQ-025 On rst=1, asynchronously: state=IDLE, fifo_rd_en=0, awvalid=0, wvalid=0, bready=0, wlast=0, awaddr=BASE_ADDR, wdata=0, wr_count=0, busy=0.
REQ-026 Reset mid-transaction SHALL abandon the transaction; the popped word is lost; first word after release goes to BASE_ADDR.

Configuration
REQ-027 With macro WR_ERR_CNT_EN defined: output err_cnt (8 bits, reset 0) increments on each bvalid&bready with bresp[1]=1, saturating at 8'hFF.
REQ-028 Without WR_ERR_CNT_EN: port err_cnt absent, no error logic; all other behaviour identical.

Verification
REQ-029 One word 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0 in FIFO, slave always ready, bresp=0 -> one AW at 0x0000_0000, wdata equal to that word, wlast=1, wr_count=1, back to IDLE after 5 cycles.
REQ-030 Three words (A*, C*, F* patterns) -> awaddr 0x00, 0x10, 0x20 in order, wr_count=3, fifo_rd_en exactly 3 pulses.
REQ-031 awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid/awaddr held stable 4 cycles, RESP entered only after AW handshake.
REQ-032 REGION_WORDS=4, 5 words -> fifth write awaddr=BASE_ADDR.
REQ-033 rst asserted in ADDR_DATA -> awvalid/wvalid low immediately; after release next word written to BASE_ADDR, wr_count=0 before it.
REQ-034 WR_ERR_CNT_EN defined, bresp=2'b10 on two writes -> err_cnt=2, wr_count=2, addresses still advance.
